store_buffer: RTL and testbench

- Posted-write FIFO between the core's memory stage and the RAM block.
- The core issues stores into the buffer and continues without waiting. The buffer drains one store per cycle into the RAM's single address/write port whenever that port is not serving a load.
- Loads that overlap a buffered store are stalled via `ld_hazard` until the conflicting entries have drained. This preserves program-order memory semantics.

---
 rtl/store_buffer.sv | 146 ++++++++++++++
 tb/tb_store_buffer.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/store_buffer.sv
// Posted-write FIFO between the core memory stage and the single-port RAM.
// Optional `SB_FLUSH_EN adds flush_req/flush_done for fence/ecall draining.

`ifndef STORE_B
`define STORE_B  2'b00
`define STORE_H  2'b01
`define STORE_W  2'b10
`endif
`ifndef NO_LOAD
`define NO_LOAD  3'b111
`define FUNCT_LB 3'b000
`define FUNCT_LH 3'b001
`define FUNCT_LW 3'b010
`define FUNCT_LBU 3'b100
`define FUNCT_LHU 3'b101
`endif

module store_buffer #(
  parameter int unsigned DEPTH = 4
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic        st_valid,
  output logic        st_ready,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_data,
  input  logic [1:0]  st_ops,
  input  logic [2:0]  ld_ops,
  input  logic [31:0] ld_addr,
  output logic        ld_hazard,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_write_data,
  output logic [1:0]  mem_storeops,
  output logic        mem_memwrite,
  output logic [2:0]  mem_loadops
`ifdef SB_FLUSH_EN
  ,
  input  logic        flush_req,
  output logic        flush_done
`endif
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [31:0]   addr_q [DEPTH];
  logic [31:0]   data_q [DEPTH];
  logic [1:0]    ops_q  [DEPTH];
  logic [AW-1:0] head_q, tail_q;
  logic [AW:0]   count_q, count_d;

  logic full, ld_active, hit, block, grant_ld, drain, push;
  logic [32:0] ld_end;
  logic [AW-1:0] off;

  // Exclusive end (addr + size) in 33 bits so no range wraps past 0xFFFFFFFF.
  function automatic logic [32:0] st_end(input logic [31:0] a, input logic [1:0] ops);
    case (ops)
      `STORE_B: st_end = {1'b0, a} + 33'd1;
      `STORE_H: st_end = {1'b0, a} + 33'd2;
      default:  st_end = {1'b0, a} + 33'd4;
    endcase
  endfunction

  always_comb begin
    case (ld_ops)
      `FUNCT_LB, `FUNCT_LBU: ld_end = {1'b0, ld_addr} + 33'd1;
      `FUNCT_LH, `FUNCT_LHU: ld_end = {1'b0, ld_addr} + 33'd2;
      default:               ld_end = {1'b0, ld_addr} + 33'd4;
    endcase
  end

  always_comb begin
    hit = 1'b0;
    off = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      off = AW'(i) - head_q;
      if (({1'b0, off} < count_q) &&
          ({1'b0, ld_addr} < st_end(addr_q[i], ops_q[i])) &&
          ({1'b0, addr_q[i]} < ld_end)) begin
        hit = 1'b1;
      end
    end
  end

  assign full      = (count_q == (AW+1)'(DEPTH));
  assign ld_active = (ld_ops != `NO_LOAD);

`ifdef SB_FLUSH_EN
  assign block      = full || hit || flush_req;
  assign st_ready   = !full && !flush_req;
  assign flush_done = flush_req && (count_q == '0);
`else
  assign block    = full || hit;
  assign st_ready = !full;
`endif

  assign ld_hazard = ld_active && block;
  assign grant_ld  = ld_active && !ld_hazard;
  // Reset suppresses the drain so a pending entry never reaches RAM on the reset edge.
  assign drain     = !reset && !grant_ld && (count_q != '0);
  assign push      = st_valid && st_ready;

  always_comb begin
    mem_write_data = data_q[head_q];
    mem_storeops   = ops_q[head_q];
    mem_memwrite   = 1'b0;
    mem_loadops    = `NO_LOAD;
    mem_addr       = ld_addr;
    if (grant_ld) begin
      mem_loadops = ld_ops;
    end else if (drain) begin
      mem_addr     = addr_q[head_q];
      mem_memwrite = 1'b1;
    end
  end

  always_comb begin
    count_d = count_q;
    case ({push, drain})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      count_q <= count_d;
      if (push)  tail_q <= tail_q + 1'b1;
      if (drain) head_q <= head_q + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!reset && push) begin
      addr_q[tail_q] <= st_addr;
      data_q[tail_q] <= st_data;
      ops_q[tail_q]  <= st_ops;
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: drain scoreboard plus directed hazard/arbitration checks.
// Define SB_FLUSH_EN for both RTL and bench to exercise the flush ports.

`timescale 1ns/1ps

`ifndef STORE_B
`define STORE_B  2'b00
`define STORE_H  2'b01
`define STORE_W  2'b10
`endif
`ifndef NO_LOAD
`define NO_LOAD  3'b111
`define FUNCT_LB 3'b000
`define FUNCT_LH 3'b001
`define FUNCT_LW 3'b010
`define FUNCT_LBU 3'b100
`define FUNCT_LHU 3'b101
`endif

module tb_store_buffer;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  ops;
  } st_entry_t;

  logic        CLK = 1'b0;
  logic        reset;
  logic        st_valid;
  logic        st_ready;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic [1:0]  st_ops;
  logic [2:0]  ld_ops;
  logic [31:0] ld_addr;
  logic        ld_hazard;
  logic [31:0] mem_addr;
  logic [31:0] mem_write_data;
  logic [1:0]  mem_storeops;
  logic        mem_memwrite;
  logic [2:0]  mem_loadops;
`ifdef SB_FLUSH_EN
  logic        flush_req;
  logic        flush_done;
`endif

  store_buffer #(.DEPTH(4)) dut (
    .CLK            (CLK),
    .reset          (reset),
    .st_valid       (st_valid),
    .st_ready       (st_ready),
    .st_addr        (st_addr),
    .st_data        (st_data),
    .st_ops         (st_ops),
    .ld_ops         (ld_ops),
    .ld_addr        (ld_addr),
    .ld_hazard      (ld_hazard),
    .mem_addr       (mem_addr),
    .mem_write_data (mem_write_data),
    .mem_storeops   (mem_storeops),
    .mem_memwrite   (mem_memwrite),
    .mem_loadops    (mem_loadops)
`ifdef SB_FLUSH_EN
    ,
    .flush_req      (flush_req),
    .flush_done     (flush_done)
`endif
  );

  always #5 CLK = ~CLK;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  st_entry_t   sb_q[$];
  st_entry_t   mon_e;
  logic [7:0]  ram [logic [31:0]];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [7:0] ram_byte(input logic [31:0] a);
    return ram.exists(a) ? ram[a] : 8'h00;
  endfunction

  function automatic logic [31:0] ram_word(input logic [31:0] a);
    return {ram_byte(a + 3), ram_byte(a + 2), ram_byte(a + 1), ram_byte(a)};
  endfunction

  // RAM model plus scoreboard: each drain must match the oldest accepted store.
  always @(negedge CLK) begin
    if (!reset && mem_memwrite) begin
      if (sb_q.size() == 0) begin
        check("drain_unexpected", {31'd0, mem_memwrite}, 32'd0);
      end else begin
        mon_e = sb_q.pop_front();
        check("drain_addr", mem_addr, mon_e.addr);
        check("drain_data", mem_write_data, mon_e.data);
        check("drain_ops", {30'd0, mem_storeops}, {30'd0, mon_e.ops});
      end
      ram[mem_addr] = mem_write_data[7:0];
      if (mem_storeops != `STORE_B) ram[mem_addr + 1] = mem_write_data[15:8];
      if (mem_storeops == `STORE_W) begin
        ram[mem_addr + 2] = mem_write_data[23:16];
        ram[mem_addr + 3] = mem_write_data[31:24];
      end
    end
    if (!reset && st_valid && st_ready) sb_q.push_back({st_addr, st_data, st_ops});
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] o);
    st_valid = 1'b1;
    st_addr  = a;
    st_data  = d;
    st_ops   = o;
  endtask

  // Counts drain cycles until the port goes idle; bounded so a stuck DUT still finishes.
  task automatic drain_count(input string tag, input int exp);
    int n;
    n = 0;
    while (mem_memwrite === 1'b1 && n < 12) begin
      n++;
      tick();
    end
    check(tag, n, exp);
  endtask

  initial begin
    reset    = 1'b1;
    st_valid = 1'b0;
    st_addr  = '0;
    st_data  = '0;
    st_ops   = `STORE_W;
    ld_ops   = `NO_LOAD;
    ld_addr  = '0;
`ifdef SB_FLUSH_EN
    flush_req = 1'b0;
`endif
    tick();
    tick();
    reset = 1'b0;
    #1;

    // Idle after reset
    for (int c = 0; c < 5; c++) begin
      check("rst_st_ready", {31'd0, st_ready}, 32'd1);
      check("rst_memwrite", {31'd0, mem_memwrite}, 32'd0);
      check("rst_loadops", {29'd0, mem_loadops}, {29'd0, `NO_LOAD});
      check("rst_hazard", {31'd0, ld_hazard}, 32'd0);
      tick();
    end

    // Word store drains next cycle, then a load of it is granted
    store(32'h10, 32'hDEADBEEF, `STORE_W);
    #1;
    check("t2_no_early_drain", {31'd0, mem_memwrite}, 32'd0);
    tick();
    st_valid = 1'b0;
    #1;
    check("t2_memwrite", {31'd0, mem_memwrite}, 32'd1);
    check("t2_addr", mem_addr, 32'h10);
    check("t2_ops", {30'd0, mem_storeops}, {30'd0, `STORE_W});
    tick();
    ld_ops  = `FUNCT_LW;
    ld_addr = 32'h10;
    #1;
    check("t2_ld_hazard", {31'd0, ld_hazard}, 32'd0);
    check("t2_ld_grant", {29'd0, mem_loadops}, {29'd0, `FUNCT_LW});
    check("t2_ld_data", ram_word(32'h10), 32'hDEADBEEF);
    ld_ops = `NO_LOAD;
    tick();

    // Byte store at 0x21: LBU 0x20 is disjoint, LH 0x20 overlaps
    store(32'h21, 32'h000000AB, `STORE_B);
    tick();
    st_valid = 1'b0;
    ld_ops   = `FUNCT_LBU;
    ld_addr  = 32'h20;
    #1;
    check("t3_lbu_hazard", {31'd0, ld_hazard}, 32'd0);
    check("t3_lbu_grant", {29'd0, mem_loadops}, {29'd0, `FUNCT_LBU});
    check("t3_lbu_nowrite", {31'd0, mem_memwrite}, 32'd0);
    tick();
    ld_ops = `FUNCT_LH;
    #1;
    check("t3_lh_hazard", {31'd0, ld_hazard}, 32'd1);
    check("t3_lh_drain", {31'd0, mem_memwrite}, 32'd1);
    check("t3_lh_drain_addr", mem_addr, 32'h21);
    check("t3_lh_loadops", {29'd0, mem_loadops}, {29'd0, `NO_LOAD});
    tick();
    check("t3_lh_hazard_clr", {31'd0, ld_hazard}, 32'd0);
    check("t3_lh_grant", {29'd0, mem_loadops}, {29'd0, `FUNCT_LH});
    check("t3_lh_addr", mem_addr, 32'h20);
    check("t3_byte20", {24'd0, ram_byte(32'h20)}, 32'h00);
    check("t3_byte21", {24'd0, ram_byte(32'h21)}, 32'hAB);
    ld_ops = `NO_LOAD;
    tick();

    // Fill to DEPTH under back-to-back disjoint loads
    ld_ops  = `FUNCT_LW;
    ld_addr = 32'h200;
    for (int k = 0; k < 4; k++) begin
      store(32'h100 + 32'(4 * k), 32'hA0 + 32'(k), `STORE_W);
      #1;
      check("t4_fill_ready", {31'd0, st_ready}, 32'd1);
      check("t4_fill_grant", {29'd0, mem_loadops}, {29'd0, `FUNCT_LW});
      check("t4_fill_nowrite", {31'd0, mem_memwrite}, 32'd0);
      tick();
    end
    st_valid = 1'b0;
    #1;
    check("t4_full_ready", {31'd0, st_ready}, 32'd0);
    check("t4_full_hazard", {31'd0, ld_hazard}, 32'd1);
    check("t4_full_drain", {31'd0, mem_memwrite}, 32'd1);
    check("t4_full_addr", mem_addr, 32'h100);
    tick();
    check("t4_c3_hazard", {31'd0, ld_hazard}, 32'd0);
    check("t4_c3_grant", {29'd0, mem_loadops}, {29'd0, `FUNCT_LW});
    check("t4_c3_ready", {31'd0, st_ready}, 32'd1);
    ld_ops = `NO_LOAD;
    #1;
    drain_count("t4_drains", 3);

    // Enqueue during drain at count 2; same-address stores land in order
    ld_ops = `FUNCT_LW;
    store(32'h40, 32'h11, `STORE_B);
    tick();
    store(32'h40, 32'h22, `STORE_B);
    tick();
    ld_ops = `NO_LOAD;
    store(32'h48, 32'h33, `STORE_W);
    #1;
    check("t5_drain1", {31'd0, mem_memwrite}, 32'd1);
    check("t5_drain1_data", mem_write_data, 32'h11);
    check("t5_ready", {31'd0, st_ready}, 32'd1);
    tick();
    st_valid = 1'b0;
    #1;
    check("t5_drain2_data", mem_write_data, 32'h22);
    drain_count("t5_drains", 2);
    check("t5_byte40", {24'd0, ram_byte(32'h40)}, 32'h22);
    check("t5_word48", ram_word(32'h48), 32'h33);

    // Reset with three pending entries discards them
    ld_ops = `FUNCT_LW;
    for (int k = 0; k < 3; k++) begin
      store(32'h300 + 32'(4 * k), 32'h55555555, `STORE_W);
      tick();
    end
    st_valid = 1'b0;
    ld_ops   = `NO_LOAD;
    reset    = 1'b1;
    sb_q.delete();
    #1;
    check("t6_rst_nowrite", {31'd0, mem_memwrite}, 32'd0);
    tick();
    reset = 1'b0;
    #1;
    for (int c = 0; c < 3; c++) begin
      check("t6_post_nowrite", {31'd0, mem_memwrite}, 32'd0);
      check("t6_post_ready", {31'd0, st_ready}, 32'd1);
      tick();
    end
    check("t6_ram_untouched", ram_word(32'h300), 32'h0);

`ifdef SB_FLUSH_EN
    begin
      int n;
      ld_ops = `FUNCT_LW;
      for (int k = 0; k < 3; k++) begin
        store(32'h400 + 32'(4 * k), 32'h77 + 32'(k), `STORE_W);
        tick();
      end
      st_valid  = 1'b0;
      flush_req = 1'b1;
      #1;
      check("fl_done_early", {31'd0, flush_done}, 32'd0);
      check("fl_ready", {31'd0, st_ready}, 32'd0);
      check("fl_hazard", {31'd0, ld_hazard}, 32'd1);
      n = 0;
      while (flush_done !== 1'b1 && n < 12) begin
        n++;
        tick();
      end
      check("fl_cycles", n, 3);
      flush_req = 1'b0;
      ld_ops    = `NO_LOAD;
      tick();
    end
`endif

    check("sb_empty", sb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
